// File: rtl/mu0_control_unit.sv
// mu0_control_unit: phase sequencer, instruction register and control decode for an
// MU0 core with ARM-style register ops, memory wait states, HALT/resume, illegal-opcode
// trapping and a retired-instruction counter.
//
// Parameters:
//   WIDTH  instruction/data word width (>= 16)
//   CNT_W  width of the retired-instruction counter
// Ports:
//   CLK, RESET                 clock (rising edge), asynchronous active-high reset
//   MEM_DATA, MEM_READY        program memory read data and access-complete flag
//   EQ, MI                     accumulator zero / negative flags
//   RUN                        resume request while halted
//   FETCH, EXEC1, EXEC2        one-hot phase indicators
//   HALTED                     sequencer parked after STP
//   IR, IR_LOAD                instruction register and its capture strobe
//   EXTRA .. MUX3_useAllBits   datapath controls
//   ILLEGAL                    one-cycle pulse while an undefined opcode executes
//   INSTR_CNT                  retired-instruction count (wraps)
module mu0_control_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] MEM_DATA,
  input  logic             MEM_READY,
  input  logic             EQ,
  input  logic             MI,
  input  logic             RUN,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic             HALTED,
  output logic [WIDTH-1:0] IR,
  output logic             IR_LOAD,
  output logic             EXTRA,
  output logic             Wren,
  output logic             MUX1,
  output logic             MUX3,
  output logic             PC_sload,
  output logic             PC_cnt_en,
  output logic             ACC_EN,
  output logic             ACC_LOAD,
  output logic             ACC_SHIFTIN,
  output logic             ADDSUB,
  output logic             MUX3_useAllBits,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [1:0] {StFetch, StExec1, StExec2, StHalt} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  // Instruction decode
  logic [3:0] op;
  logic       is_arm;
  logic op_lda, op_sta, op_add, op_sub, op_jmp, op_jmi, op_jeq, op_stp;
  logic op_ldi, op_lsr, op_asr, op_arm, op_ill;
  logic mem_op, two_phase;

  assign op        = ir_q[WIDTH-1 -: 4];
  assign is_arm    = ir_q[WIDTH-1] & ir_q[WIDTH-2];
  assign op_lda    = (op == 4'h0);
  assign op_sta    = (op == 4'h1);
  assign op_add    = (op == 4'h2);
  assign op_sub    = (op == 4'h3);
  assign op_jmp    = (op == 4'h4);
  assign op_jmi    = (op == 4'h5);
  assign op_jeq    = (op == 4'h6);
  assign op_stp    = (op == 4'h7);
  assign op_ldi    = (op == 4'h8);
  assign op_lsr    = (op == 4'hA);
  assign op_asr    = (op == 4'hB);
  // ARM sub-ops live in IR[6:4]; only 0xx are defined
  assign op_arm    = is_arm & ~ir_q[6];
  assign op_ill    = (op == 4'h9) | (is_arm & ir_q[6]);
  assign mem_op    = op_lda | op_sta | op_add | op_sub;
  assign two_phase = op_lda | op_add | op_sub;

  // Phase decode
  logic in_fetch, in_exec1, in_exec2, in_halt;
  logic waiting, rdy_ok, live;

  assign in_fetch = (state_q == StFetch);
  assign in_exec1 = (state_q == StExec1);
  assign in_exec2 = (state_q == StExec2);
  assign in_halt  = (state_q == StHalt);

  // Phases that sit on a memory access only fire side effects on the ready cycle
  assign waiting  = in_fetch | in_exec2 | (in_exec1 & mem_op);
  assign rdy_ok   = ~waiting | MEM_READY;
  // Reset blanks every strobe, including the ones the FETCH state would raise
  assign live     = ~RESET;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (MEM_READY) state_d = StExec1;
      end
      StExec1: begin
        if (op_stp) begin
          state_d = StHalt;
        end else if (mem_op && !MEM_READY) begin
          state_d = StExec1;
        end else if (two_phase) begin
          state_d = StExec2;
        end else begin
          state_d = StFetch;
        end
      end
      StExec2: begin
        if (MEM_READY) state_d = StFetch;
      end
      StHalt: begin
        if (RUN) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // An instruction retires when its execute phase hands back to FETCH or parks in HALT;
  // resuming from HALT does not retire the STP a second time.
  assign retire = (in_exec1 | in_exec2) & ((state_d == StFetch) | (state_d == StHalt));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StFetch;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_fetch && MEM_READY) ir_q <= MEM_DATA;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Raw side-effect strobes before memory/reset gating
  logic sload_raw, cnt_en_raw, acc_en_raw, acc_load_raw;

  assign sload_raw    = in_exec1 & (op_jmp | (op_jmi & MI) | (op_jeq & EQ));
  assign cnt_en_raw   = (in_exec2 & two_phase)
                      | (in_exec1 & (op_sta | op_ldi | op_lsr | op_asr | op_arm | op_ill))
                      | (in_exec1 & ((op_jmi & ~MI) | (op_jeq & ~EQ)))
                      | (in_halt & RUN);
  assign acc_en_raw   = (in_exec2 & two_phase) | (in_exec1 & (op_ldi | op_lsr | op_asr));
  assign acc_load_raw = (in_exec2 & two_phase) | (in_exec1 & op_ldi);

  assign FETCH     = in_fetch;
  assign EXEC1     = in_exec1;
  assign EXEC2     = in_exec2;
  assign HALTED    = in_halt;
  assign IR        = ir_q;
  assign INSTR_CNT = cnt_q;

  assign IR_LOAD   = live & rdy_ok & in_fetch;
  assign PC_sload  = live & rdy_ok & sload_raw;
  assign PC_cnt_en = live & rdy_ok & cnt_en_raw;
  assign ACC_EN    = live & rdy_ok & acc_en_raw;
  assign ACC_LOAD  = live & rdy_ok & acc_load_raw;

  // Level controls held steady across wait states
  assign EXTRA           = live & in_exec1 & two_phase;
  assign MUX1            = live & in_exec1 & mem_op;
  assign Wren            = live & in_exec1 & op_sta;
  assign MUX3            = live & ((in_exec2 & op_lda) | (in_exec1 & op_ldi));
  assign ADDSUB          = live & in_exec2 & op_add;
  assign ACC_SHIFTIN     = live & in_exec1 & op_asr & MI;
  assign MUX3_useAllBits = live & ((in_exec2 & op_lda) | (in_exec1 & (op_lsr | op_asr)));
  assign ILLEGAL         = live & in_exec1 & op_ill;

endmodule

// File: tb/tb_mu0_control_unit.sv
// Directed bench for mu0_control_unit (WIDTH=16, CNT_W=4). An instruction-level model
// predicts every output each cycle; literal checks pin the scenarios worked by hand.
module tb_mu0_control_unit;

  logic        CLK, RESET, MEM_READY, EQ, MI, RUN;
  logic [15:0] MEM_DATA, IR;
  logic        FETCH, EXEC1, EXEC2, HALTED, IR_LOAD, EXTRA, Wren, MUX1, MUX3;
  logic        PC_sload, PC_cnt_en, ACC_EN, ACC_LOAD, ACC_SHIFTIN, ADDSUB;
  logic        MUX3_useAllBits, ILLEGAL;
  logic [3:0]  INSTR_CNT;

  mu0_control_unit #(.WIDTH(16), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .EQ(EQ), .MI(MI), .RUN(RUN), .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2),
    .HALTED(HALTED), .IR(IR), .IR_LOAD(IR_LOAD), .EXTRA(EXTRA), .Wren(Wren),
    .MUX1(MUX1), .MUX3(MUX3), .PC_sload(PC_sload), .PC_cnt_en(PC_cnt_en),
    .ACC_EN(ACC_EN), .ACC_LOAD(ACC_LOAD), .ACC_SHIFTIN(ACC_SHIFTIN), .ADDSUB(ADDSUB),
    .MUX3_useAllBits(MUX3_useAllBits), .ILLEGAL(ILLEGAL), .INSTR_CNT(INSTR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Mnemonic classes
  localparam int LDA = 0, STA = 1, ADD = 2, SUB = 3, JMP = 4, JMI = 5, JEQ = 6, STP = 7;
  localparam int LDI = 8, LSR = 10, ASR = 11, ARM = 12, ILL = 13;

  // Model state: phase 0=fetch 1=exec1 2=exec2 3=halt
  int         m_phase;
  logic [15:0] m_ir;
  logic [3:0]  m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mn(input logic [15:0] w);
    if (w[15:14] == 2'b11) return w[6] ? ILL : ARM;
    case (w[15:12])
      4'h0: return LDA;
      4'h1: return STA;
      4'h2: return ADD;
      4'h3: return SUB;
      4'h4: return JMP;
      4'h5: return JMI;
      4'h6: return JEQ;
      4'h7: return STP;
      4'h8: return LDI;
      4'hA: return LSR;
      4'hB: return ASR;
      default: return ILL;
    endcase
  endfunction

  function automatic logic [16:0] dut_vec();
    return {FETCH, EXEC1, EXEC2, HALTED, IR_LOAD, EXTRA, Wren, MUX1, MUX3, PC_sload,
            PC_cnt_en, ACC_EN, ACC_LOAD, ACC_SHIFTIN, ADDSUB, MUX3_useAllBits, ILLEGAL};
  endfunction

  // Expected control word, written per instruction from the behaviour tables
  function automatic logic [16:0] exp_vec(input int ph, input logic [15:0] w,
                                          input logic rdy, input logic eq, input logic mi,
                                          input logic run);
    logic f, e1, e2, h, irl, ex, wr, m1, m3, sl, ce, ae, al, si, as, ab, il;
    int m;
    {f, e1, e2, h, irl, ex, wr, m1, m3, sl, ce, ae, al, si, as, ab, il} = '0;
    m = mn(w);
    case (ph)
      0: begin f = 1; irl = rdy; end
      1: begin
        e1 = 1;
        case (m)
          LDA, ADD, SUB: begin ex = 1; m1 = 1; end
          STA: begin m1 = 1; wr = 1; ce = rdy; end
          JMP: sl = 1;
          JMI: if (mi) sl = 1; else ce = 1;
          JEQ: if (eq) sl = 1; else ce = 1;
          LDI: begin m3 = 1; ce = 1; ae = 1; al = 1; end
          LSR: begin ce = 1; ae = 1; ab = 1; end
          ASR: begin ce = 1; ae = 1; ab = 1; si = mi; end
          ARM: ce = 1;
          ILL: begin ce = 1; il = 1; end
          default: ;
        endcase
      end
      2: begin
        e2 = 1; ae = rdy; al = rdy; ce = rdy;
        if (m == LDA) begin m3 = 1; ab = 1; end
        if (m == ADD) as = 1;
      end
      default: begin h = 1; ce = run; end
    endcase
    return {f, e1, e2, h, irl, ex, wr, m1, m3, sl, ce, ae, al, si, as, ab, il};
  endfunction

  // One clock: compare at the falling edge, then advance the model across the rising edge
  task automatic step();
    int np, m;
    logic [15:0] nir;
    logic [3:0] ncnt;
    @(negedge CLK);
    chk("ctrl", dut_vec(), exp_vec(m_phase, m_ir, MEM_READY, EQ, MI, RUN));
    chk("ir", IR, m_ir);
    chk("instr_cnt", INSTR_CNT, m_cnt);
    np = m_phase; nir = m_ir; ncnt = m_cnt; m = mn(m_ir);
    case (m_phase)
      0: if (MEM_READY) begin np = 1; nir = MEM_DATA; end
      1: begin
        if (m == STP) begin np = 3; ncnt = m_cnt + 1; end
        else if ((m == LDA || m == STA || m == ADD || m == SUB) && !MEM_READY) np = 1;
        else if (m == LDA || m == ADD || m == SUB) np = 2;
        else begin np = 0; ncnt = m_cnt + 1; end
      end
      2: if (MEM_READY) begin np = 0; ncnt = m_cnt + 1; end
      default: if (RUN) np = 0;
    endcase
    @(posedge CLK);
    m_phase = np; m_ir = nir; m_cnt = ncnt;
    #1;
  endtask

  // Run one instruction to completion with wf/w1/w2 not-ready cycles in each phase
  task automatic run_op(input logic [15:0] w, input int wf, input int w1, input int w2);
    bit started = 0, done = 0;
    MEM_DATA = w;
    for (int n = 0; n < 40 && !done; n++) begin
      case (m_phase)
        0: if (wf > 0) begin MEM_READY = 0; wf--; end else MEM_READY = 1;
        1: if (w1 > 0) begin MEM_READY = 0; w1--; end else MEM_READY = 1;
        2: if (w2 > 0) begin MEM_READY = 0; w2--; end else MEM_READY = 1;
        default: MEM_READY = 1;
      endcase
      step();
      if (m_phase == 1) started = 1;
      if (started && (m_phase == 0 || m_phase == 3)) done = 1;
    end
    if (!done) chk("op_timeout", 0, 1);
    MEM_READY = 1;
  endtask

  int wren_n, e1_n;

  initial begin
    RESET = 1; MEM_DATA = 16'h0005; MEM_READY = 1; EQ = 0; MI = 0; RUN = 0;
    #2;
    chk("rst_fetch", FETCH, 1);
    chk("rst_ir", IR, 0);
    chk("rst_cnt", INSTR_CNT, 0);
    chk("rst_strobes", dut_vec() & 17'h0FFFF, 0);
    m_phase = 0; m_ir = 0; m_cnt = 0;
    @(posedge CLK); #1 RESET = 0;

    // LDA 0x0005
    #1 chk("lda_irload", IR_LOAD, 1);
    step();
    chk("lda_ir", IR, 16'h0005);
    chk("lda_e1", {EXEC1, MUX1, EXTRA}, 3'b111);
    step();
    chk("lda_e2", {EXEC2, ACC_EN, ACC_LOAD, PC_cnt_en, MUX3}, 5'h1f);
    step();
    chk("lda_cnt", INSTR_CNT, 1);
    chk("lda_back", FETCH, 1);

    // STA with two wait cycles in EXEC1
    MEM_DATA = 16'h1010; MEM_READY = 1; step();
    wren_n = 0; e1_n = 0; MEM_READY = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("sta_wait_cnt_en", PC_cnt_en, 0);
      wren_n += int'(Wren); e1_n += int'(EXEC1);
      step();
    end
    MEM_READY = 1;
    #1 chk("sta_ready_cnt_en", PC_cnt_en, 1);
    wren_n += int'(Wren); e1_n += int'(EXEC1);
    step();
    chk("sta_wren_cycles", wren_n, 3);
    chk("sta_exec1_cycles", e1_n, 3);
    chk("sta_done", FETCH, 1);

    // JMI taken / not taken
    MEM_DATA = 16'h5000; MI = 1; step();
    chk("jmi_mi1", {PC_sload, PC_cnt_en}, 2'b10); step();
    MI = 0; step();
    chk("jmi_mi0", {PC_sload, PC_cnt_en}, 2'b01); step();

    // ASR with MI
    MEM_DATA = 16'hB000; MI = 1; step();
    chk("asr", {ACC_SHIFTIN, ACC_EN, MUX3_useAllBits, ACC_LOAD}, 4'b1110); step();
    MI = 0;

    // Illegal opcode, then STP / HALT / RUN
    MEM_DATA = 16'h9000; step();
    chk("ill_pulse", {ILLEGAL, PC_cnt_en}, 2'b11); step();
    chk("ill_after", {FETCH, ILLEGAL}, 2'b10);
    MEM_DATA = 16'h7000; step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("halt_hold", {HALTED, PC_cnt_en}, 2'b10);
      step();
    end
    RUN = 1;
    #1 chk("halt_run", PC_cnt_en, 1);
    step(); RUN = 0;
    #1 chk("resume", FETCH, 1);

    // Model-checked mix: waits in every phase, RUN ignored outside HALT, ARM ops
    RUN = 1;
    run_op(16'h8123, 1, 0, 0);
    run_op(16'h0040, 0, 1, 1);
    RUN = 0;
    run_op(16'hA000, 0, 2, 0);
    run_op(16'h2000, 1, 1, 2);
    run_op(16'h3000, 0, 0, 1);
    EQ = 1; run_op(16'h6000, 0, 0, 0);
    EQ = 0; run_op(16'h6000, 0, 0, 0);
    run_op(16'h4000, 0, 0, 0);
    MI = 1; run_op(16'h5000, 0, 2, 0);
    run_op(16'hB000, 0, 0, 0);
    MI = 0; run_op(16'hB000, 0, 0, 0);
    run_op(16'hC000, 0, 0, 0);
    run_op(16'hD010, 0, 0, 0);
    run_op(16'hE020, 0, 0, 0);
    run_op(16'hF030, 0, 0, 0);
    run_op(16'hC040, 0, 0, 0);
    run_op(16'hF070, 0, 0, 0);
    run_op(16'h1234, 2, 1, 0);
    run_op(16'h7000, 0, 0, 0);
    step();
    RUN = 1; step(); RUN = 0;

    // Asynchronous reset during EXEC2
    MEM_DATA = 16'h0777; MEM_READY = 1; step(); step();
    chk("ar_in_e2", EXEC2, 1);
    MEM_READY = 0;
    #2 RESET = 1;
    #1;
    chk("ar_phase", {FETCH, EXEC2}, 2'b10);
    chk("ar_ir", IR, 0);
    chk("ar_strobes", dut_vec() & 17'h0FFFF, 0);
    m_phase = 0; m_ir = 0; m_cnt = 0;
    MEM_READY = 1;
    #1 chk("ar_irload_blank", IR_LOAD, 0);
    @(posedge CLK); #1;
    chk("ar_ir_held", IR, 0);
    RESET = 0;

    // 17 retirements on a 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++) run_op(16'h8000 | 16'(i), 0, 0, 0);
    chk("cnt_wrap", INSTR_CNT, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
